// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field ranges, NOP encoding and the
// fetch-stage state type.
package mips_pkg;

  localparam int unsigned RS_MSB       = 25;
  localparam int unsigned RS_LSB       = 21;
  localparam int unsigned RT_MSB       = 20;
  localparam int unsigned RT_LSB       = 16;
  localparam int unsigned IMM16_MSB    = 15;
  localparam int unsigned IMM16_LSB    = 0;
  localparam int unsigned TARGET26_MSB = 25;
  localparam int unsigned TARGET26_LSB = 0;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [4:0] rs_field(input logic [31:0] instr);
    return instr[RS_MSB:RS_LSB];
  endfunction

  function automatic logic [4:0] rt_field(input logic [31:0] instr);
    return instr[RT_MSB:RT_LSB];
  endfunction

  function automatic logic [15:0] imm16_field(input logic [31:0] instr);
    return instr[IMM16_MSB:IMM16_LSB];
  endfunction

  function automatic logic [25:0] target26_field(input logic [31:0] instr);
    return instr[TARGET26_MSB:TARGET26_LSB];
  endfunction

endpackage

// File: rtl/fetch_stage_next_pc_sel.sv
// Next-PC priority mux: jr/jalr over j/jal over taken branch over sequential.
module next_pc_sel
  import mips_pkg::*;
(
  input  logic        jump_reg_i,
  input  logic        jump_target_i,
  input  logic        jump_branch_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] fetch_pc_i,
  output logic [31:0] next_pc_o
);

  logic [15:0] imm;
  logic [31:0] br_off;
  logic [31:0] jmp_tgt;
  logic        unused_opcode;

  assign imm           = imm16_field(instr_i);
  assign br_off        = {{14{imm[15]}}, imm, 2'b00};
  assign jmp_tgt       = {pc_id_i[31:28], target26_field(instr_i), 2'b00};
  assign unused_opcode = ^instr_i[31:26];

  always_comb begin
    next_pc_o = fetch_pc_i + 32'd4;
    if (jump_reg_i) begin
      next_pc_o = rs_data_i;
    end else if (jump_target_i) begin
      next_pc_o = jmp_tgt;
    end else if (jump_branch_i) begin
      next_pc_o = pc_id_i + 32'd4 + br_off;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, synchronous
// ROM addressing and debug event counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned IMEM_AW   = 10,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               JumpBranch,
  input  logic               JumpTarget,
  input  logic               JumpReg,
  input  logic [31:0]        instr_in,
  input  logic [31:0]        pc_in,
  input  logic [31:0]        RsData,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_out,
  output logic [31:0]        instr_out,
  output logic [CNT_W-1:0]   fetch_cnt,
  output logic [CNT_W-1:0]   redirect_cnt
);

  import mips_pkg::*;

  fetch_state_e     state_q;
  logic [31:0]      fetch_pc_q, fetch_pc_d, next_pc;
  logic [CNT_W-1:0] fetch_cnt_q, redirect_cnt_q;
  logic             advance;
  logic             redirect;

  next_pc_sel u_next_pc_sel (
    .jump_reg_i    (JumpReg),
    .jump_target_i (JumpTarget),
    .jump_branch_i (JumpBranch),
    .instr_i       (instr_in),
    .pc_id_i       (pc_in),
    .rs_data_i     (RsData),
    .fetch_pc_i    (fetch_pc_q),
    .next_pc_o     (next_pc)
  );

  assign advance  = (state_q == RUN) && en;
  assign redirect = JumpReg | JumpTarget | JumpBranch;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (advance) begin
      fetch_pc_d = next_pc;
    end
  end

  // The ROM is addressed with the PC that will be current next cycle, so its
  // one-cycle latency lines data up with pc_out; a stall re-reads the same word.
  always_comb begin
    if (state_q == BOOT) begin
      imem_addr = RESET_PC[IMEM_AW+1:2];
    end else begin
      imem_addr = fetch_pc_d[IMEM_AW+1:2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= BOOT;
      fetch_pc_q     <= RESET_PC;
      fetch_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (en) begin
            fetch_pc_q  <= fetch_pc_d;
            fetch_cnt_q <= fetch_cnt_q + CNT_W'(1);
            if (redirect) begin
              redirect_cnt_q <= redirect_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  assign instr_out    = (state_q == RUN) ? imem_rdata : NOP_INSTR;
  assign pc_out       = (state_q == RUN) ? fetch_pc_q : RESET_PC;
  assign fetch_cnt    = fetch_cnt_q;
  assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, branch, jump priority, jump
// target, wrap, and reset mid-stall with a narrow counter instance.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, en, JumpBranch, JumpTarget, JumpReg;
  logic [31:0] instr_in, pc_in, RsData;
  logic [9:0]  imem_addr, imem_addr4;
  logic [31:0] rdata, rdata4;
  logic [31:0] pc_out, instr_out, pc_out4, instr_out4;
  logic [15:0] fetch_cnt, redirect_cnt;
  logic [3:0]  fetch_cnt4, redirect_cnt4;
  logic [31:0] rom [0:1023];
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  fetch_stage u_dut (
    .clk(clk), .rst(rst), .en(en), .JumpBranch(JumpBranch), .JumpTarget(JumpTarget),
    .JumpReg(JumpReg), .instr_in(instr_in), .pc_in(pc_in), .RsData(RsData),
    .imem_addr(imem_addr), .imem_rdata(rdata), .pc_out(pc_out), .instr_out(instr_out),
    .fetch_cnt(fetch_cnt), .redirect_cnt(redirect_cnt)
  );

  fetch_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .JumpBranch(JumpBranch), .JumpTarget(JumpTarget),
    .JumpReg(JumpReg), .instr_in(instr_in), .pc_in(pc_in), .RsData(RsData),
    .imem_addr(imem_addr4), .imem_rdata(rdata4), .pc_out(pc_out4), .instr_out(instr_out4),
    .fetch_cnt(fetch_cnt4), .redirect_cnt(redirect_cnt4)
  );

  always @(posedge clk) begin
    rdata  <= rom[imem_addr];
    rdata4 <= rom[imem_addr4];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; JumpBranch = 1'b0; JumpTarget = 1'b0; JumpReg = 1'b0;
    instr_in = '0; pc_in = '0; RsData = '0;
    tick(); tick();
    total++; if (instr_out !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr_out, 32'h0); end
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_out, 32'h0); end
    total++; if (imem_addr !== 10'd0) begin bad++; $display("FAIL reset_addr got=%0d exp=0", imem_addr); end
    total++; if (fetch_cnt !== 16'd0 || redirect_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", fetch_cnt, redirect_cnt); end
  endtask

  task automatic test_boot();
    rst = 1'b1; #1;
    total++; if (instr_out !== 32'h0 || pc_out !== 32'h0) begin bad++; $display("FAIL boot_nop got=%h@%h exp=0@0", instr_out, pc_out); end
    tick();
    total++; if (instr_out !== 32'h2008_0005 || pc_out !== 32'h0) begin bad++; $display("FAIL boot_first got=%h@%h exp=20080005@0", instr_out, pc_out); end
    total++; if (imem_addr !== 10'd1 || fetch_cnt !== 16'd0) begin bad++; $display("FAIL boot_addr got=%0d cnt=%0d exp=1 cnt=0", imem_addr, fetch_cnt); end
    tick();
    total++; if (instr_out !== 32'h2009_0007 || pc_out !== 32'h4) begin bad++; $display("FAIL boot_second got=%h@%h exp=20090007@4", instr_out, pc_out); end
    total++; if (fetch_cnt !== 16'd1) begin bad++; $display("FAIL boot_cnt1 got=%0d exp=1", fetch_cnt); end
    tick();
    total++; if (pc_out !== 32'h8 || fetch_cnt !== 16'd2) begin bad++; $display("FAIL boot_cnt2 got pc=%h cnt=%0d exp pc=8 cnt=2", pc_out, fetch_cnt); end
  endtask

  task automatic test_stall();
    en = 1'b0; JumpReg = 1'b1; RsData = 32'h100; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_addr !== 10'd2) begin bad++; $display("FAIL stall_addr%0d got=%0d exp=2", i, imem_addr); end
      tick();
      total++; if (pc_out !== 32'h8 || instr_out !== 32'hA000_0002) begin bad++; $display("FAIL stall_out%0d got=%h@%h exp=a0000002@8", i, instr_out, pc_out); end
      total++; if (fetch_cnt !== 16'd2 || redirect_cnt !== 16'd0) begin bad++; $display("FAIL stall_cnt%0d got=%0d/%0d exp=2/0", i, fetch_cnt, redirect_cnt); end
    end
    JumpReg = 1'b0; en = 1'b1;
    tick();
    total++; if (pc_out !== 32'hC || instr_out !== 32'hA000_0003 || fetch_cnt !== 16'd3) begin bad++; $display("FAIL stall_resume got=%h@%h cnt=%0d exp=a0000003@c cnt=3", instr_out, pc_out, fetch_cnt); end
  endtask

  task automatic test_branch();
    tick(); tick();
    pc_in = 32'h10; instr_in = 32'h1000_FFFE; JumpBranch = 1'b1; #1;
    total++; if (pc_out !== 32'h14 || instr_out !== 32'hA000_0005) begin bad++; $display("FAIL branch_slot got=%h@%h exp=a0000005@14", instr_out, pc_out); end
    total++; if (imem_addr !== 10'd3) begin bad++; $display("FAIL branch_addr got=%0d exp=3", imem_addr); end
    tick();
    JumpBranch = 1'b0;
    total++; if (pc_out !== 32'hC || instr_out !== 32'hA000_0003) begin bad++; $display("FAIL branch_tgt got=%h@%h exp=a0000003@c", instr_out, pc_out); end
    total++; if (redirect_cnt !== 16'd1 || fetch_cnt !== 16'd6) begin bad++; $display("FAIL branch_cnt got=%0d/%0d exp=1/6", redirect_cnt, fetch_cnt); end
  endtask

  task automatic test_jump_priority();
    JumpReg = 1'b1; JumpTarget = 1'b1; JumpBranch = 1'b1; RsData = 32'h40; instr_in = 32'h0800_0100;
    tick();
    JumpReg = 1'b0; JumpTarget = 1'b0; JumpBranch = 1'b0;
    total++; if (pc_out !== 32'h40 || instr_out !== 32'hA000_0010) begin bad++; $display("FAIL prio_pc got=%h@%h exp=a0000010@40", instr_out, pc_out); end
    total++; if (redirect_cnt !== 16'd2) begin bad++; $display("FAIL prio_cnt got=%0d exp=2", redirect_cnt); end
  endtask

  task automatic test_jump_target();
    pc_in = 32'h3000_0000; instr_in = 32'h0BFF_FFFF; JumpTarget = 1'b1;
    tick();
    JumpTarget = 1'b0;
    total++; if (pc_out !== 32'h3FFF_FFFC || instr_out !== 32'hA000_03FF) begin bad++; $display("FAIL jtgt_pc got=%h@%h exp=a00003ff@3ffffffc", instr_out, pc_out); end
    tick();
    total++; if (pc_out !== 32'h4000_0000 || instr_out !== 32'h2008_0005) begin bad++; $display("FAIL jtgt_alias got=%h@%h exp=20080005@40000000", instr_out, pc_out); end
    JumpReg = 1'b1; RsData = 32'hFFFF_FFFC;
    tick();
    JumpReg = 1'b0;
    tick();
    total++; if (pc_out !== 32'h0 || instr_out !== 32'h2008_0005) begin bad++; $display("FAIL pc_wrap got=%h@%h exp=20080005@0", instr_out, pc_out); end
    total++; if (fetch_cnt !== 16'd11 || redirect_cnt !== 16'd4) begin bad++; $display("FAIL wrap_cnt got=%0d/%0d exp=11/4", fetch_cnt, redirect_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    rst = 1'b0; tick(); rst = 1'b1; tick();
    for (int i = 0; i < 17; i++) tick();
    total++; if (fetch_cnt4 !== 4'd1 || fetch_cnt !== 16'd17) begin bad++; $display("FAIL cnt_wrap got=%0d/%0d exp=1/17", fetch_cnt4, fetch_cnt); end
    total++; if (pc_out4 !== 32'h44) begin bad++; $display("FAIL cnt_wrap_pc got=%h exp=44", pc_out4); end
    en = 1'b0; tick();
    rst = 1'b0; tick();
    total++; if (instr_out4 !== 32'h0 || pc_out4 !== 32'h0 || imem_addr4 !== 10'd0) begin bad++; $display("FAIL rst_stall_out got=%h@%h addr=%0d exp=0@0 addr=0", instr_out4, pc_out4, imem_addr4); end
    total++; if (fetch_cnt4 !== 4'd0 || redirect_cnt4 !== 4'd0 || fetch_cnt !== 16'd0) begin bad++; $display("FAIL rst_stall_cnt got=%0d/%0d/%0d exp=0/0/0", fetch_cnt4, redirect_cnt4, fetch_cnt); end
    rst = 1'b1; tick();
    total++; if (instr_out4 !== 32'h2008_0005 || pc_out4 !== 32'h0) begin bad++; $display("FAIL rst_stall_run got=%h@%h exp=20080005@0", instr_out4, pc_out4); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 32'hA000_0000 + i;
    rom[0] = 32'h2008_0005;
    rom[1] = 32'h2009_0007;
    test_reset();
    test_boot();
    test_stall();
    test_branch();
    test_jump_priority();
    test_jump_target();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of the IF→ID pipeline registers.
- Owns the PC register and selects the next PC from ID-stage redirect signals (branch, jump, jump-register).
- Drives a synchronous instruction ROM with 1-cycle read latency.
- Presents an instruction/PC pair aligned for capture by the IF→ID registers. Also provides fetch and redirect event counters for debug stepping.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first instruction fetched after reset.
- IMEM_AW, 10, word-address width of the instruction ROM.
- NOP_INSTR, 32'h0000_0000, instruction presented while no valid fetch data exists (sll $0,$0,0).
- CNT_W, 16, width of the debug event counters.

Ports:
- clk  in  1  pipeline clock (mipsclk domain).
- rst  in  1  synchronous, active-low reset.
- en  in  1  stage enable; low = stall/hold (from ~stall & (run_mode|step_pulse)).
- JumpBranch  in  1  ID: conditional branch taken.
- JumpTarget  in  1  ID: j/jal.
- JumpReg  in  1  ID: jr/jalr.
- instr_in  in  32  instruction currently in ID (source of immediate and target fields).
- pc_in  in  32  PC of instruction currently in ID.
- RsData  in  32  forwarded rs value from ID.
- imem_addr  out  IMEM_AW  word address to instruction ROM.
- imem_rdata  in  32  ROM data, valid one clk after imem_addr.
- pc_out  out  32  byte PC of instr_out.
- instr_out  out  32  fetched instruction.
- fetch_cnt  out  CNT_W  number of enabled fetch cycles since reset.
- redirect_cnt  out  CNT_W  number of enabled cycles with a redirect taken.

Behaviour:
- Single clock, clk. Reset is synchronous and active-low: rst sampled low at a rising edge resets all state.
- State machine has two states, BOOT and RUN.
  - Reset → BOOT.
  - BOOT → RUN on the first rising edge with rst high. This transition does not depend on en.
  - RUN → RUN until the next reset.
- Registers: fetch_pc (32b), state, fetch_cnt, redirect_cnt. Reset values:
  - fetch_pc = RESET_PC; state = BOOT; both counters = 0.
- Output values:
  - In BOOT: instr_out = NOP_INSTR, pc_out = RESET_PC.
  - In RUN: instr_out = imem_rdata, pc_out = fetch_pc.
- Next-PC select, in priority order:
  - JumpReg → RsData.
  - else JumpTarget → {pc_in[31:28], instr_in[25:0], 2'b00}.
  - else JumpBranch → pc_in + 4 + ({{14{instr_in[15]}}, instr_in[15:0], 2'b00}).
  - else → fetch_pc + 4.
  - All adds are 32-bit modulo (wrap past 32'hFFFF_FFFC silently).
- Branch delay slot is architectural: the instruction already fetched when a redirect arrives is never squashed.
- imem_addr generation:
  - BOOT: RESET_PC[IMEM_AW+1:2].
  - RUN with en=1: next_pc[IMEM_AW+1:2].
  - RUN with en=0: fetch_pc[IMEM_AW+1:2]. Re-reading the same word keeps instr_out stable across stalls of any length.
- fetch_pc update:
  - BOOT: holds RESET_PC, so the RESET_PC word is read during BOOT and shown in the first RUN cycle.
  - RUN with en=1: fetch_pc ← next_pc.
  - RUN with en=0: hold.
- Redirect inputs are ignored when en=0. ID is held at the same time, so the redirect is re-presented when en returns to 1.
- PC bits above IMEM_AW+1 are kept in fetch_pc and pc_out but do not address the ROM (aliasing is allowed).
- Counters, in RUN with en=1:
  - fetch_cnt += 1.
  - redirect_cnt += 1 if any of JumpReg, JumpTarget, JumpBranch is high.
  - Both wrap at 2^CNT_W. Neither counts in BOOT.
- Simultaneous redirect flags resolve by the priority above; no error is flagged.
- Reset asserted mid-stall or mid-redirect:
  - Reset wins.
  - On the next cycle: BOOT, imem_addr = RESET_PC word, instr_out = NOP_INSTR.
- Latency:
  - Redirect sampled in cycle N → target instruction on instr_out in cycle N+1.
  - The delay-slot instruction is the one on instr_out in cycle N.

Decomposition:
- Shared package mips_pkg holds:
  - Field ranges: rs, rt, imm16, target26.
  - NOP_INSTR.
  - Fetch state encoding (BOOT=1'b0, RUN=1'b1).
- One sub-module, next_pc_sel: purely combinational priority mux and adders. Keeps the branch/jump arithmetic unit-testable.
- ROM stays outside the block.

Test Plan:
- Boot:
  - Stimulus: rst low 2 cycles, then high; en=1; ROM[0]=0x20080005, ROM[1]=0x20090007.
  - Required: cycle after release instr_out=NOP, pc_out=0; then 0x20080005 @ pc 0; then 0x20090007 @ pc 4; fetch_cnt=2.
- Stall:
  - Stimulus: en=0 for 3 cycles at pc 0x8.
  - Required: instr_out, pc_out and imem_addr stay constant (addr 2) for 3 cycles; fetch_cnt unchanged; resumes with pc 0xC.
- Branch:
  - Stimulus: pc_in=0x10, instr_in imm=0xFFFE, JumpBranch=1.
  - Required: next cycle pc_out=0x0C (0x10+4−8); redirect_cnt+1; delay-slot instruction at 0x14 was presented the cycle before.
- Jump priority:
  - Stimulus: JumpReg=1, JumpTarget=1, RsData=0x40, instr_in[25:0]=0x100.
  - Required: pc_out=0x40 next cycle.
- Jump target:
  - Stimulus: pc_in=0x3000_0000, instr_in[25:0]=0x3FFFFFF, JumpTarget=1.
  - Required: pc_out=0x3FFF_FFFC.
- Reset mid-stall and counter wrap:
  - Stimulus: CNT_W=4 with 17 enabled fetches, then rst low while en=0.
  - Required: fetch_cnt=1 before the reset; after reset, BOOT with instr_out=NOP, pc_out=RESET_PC, counters 0.
